// File: rtl/rot_amount_finder_if.sv
`default_nettype none
// ============================================================================
// Module   : rot_amount_finder_if
// Purpose  : Request/result bundle for the rotate-amount finder. The master
//            side issues a search (start/abort plus operands); the slave side
//            reports status and the recovered rotate amounts.
// Revision : 1.0  initial release
// ============================================================================
interface rot_amount_finder_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] src;
  logic [WIDTH-1:0] target;
  logic             busy;
  logic             done;
  logic             found;
  logic [SHW-1:0]   amount_right;
  logic [SHW-1:0]   amount_left;

  // Requester: drives the operands and control, observes the result
  modport master (
    output start, abort, src, target,
    input  busy, done, found, amount_right, amount_left
  );

  // Finder: consumes the request, drives status and result
  modport slave (
    input  start, abort, src, target,
    output busy, done, found, amount_right, amount_left
  );
endinterface
`default_nettype wire

// File: rtl/rot_amount_finder.sv
`default_nettype none
// ============================================================================
// Module   : rot_amount_finder
// Purpose  : Recovers the smallest right-rotate amount k such that
//            rotr(src, k) == target, one candidate per clock, and reports the
//            equivalent left-rotate amount (WIDTH-k) mod WIDTH.
// Revision : 1.0  initial release
// ============================================================================
module rot_amount_finder #(
  parameter int WIDTH = 32,  // power of two, 2..32
  parameter int SHW   = 5    // log2(WIDTH)
) (
  input  wire                  clk,
  input  wire                  rst_n,
  rot_amount_finder_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] rot_r;     // source, rotated right by cnt so far
  logic [WIDTH-1:0] tgt_r;     // captured target
  logic [SHW-1:0]   cnt;       // candidate amount currently in rot_r
  logic             busy_r;
  logic             done_r;
  logic             found_r;
  logic [SHW-1:0]   right_r;
  logic [SHW-1:0]   left_r;
  logic [SHW-1:0]   cnt_neg;

  // WIDTH is a power of two, so (WIDTH-cnt) mod WIDTH is the SHW-bit negation
  // (k=0 naturally wraps to 0 instead of WIDTH).
  assign cnt_neg = SHW'(0) - cnt;

  // Search FSM: captures operands, walks one rotate step per clock, and
  // registers every output so nothing combinational reaches the ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      rot_r   <= '0;
      tgt_r   <= '0;
      cnt     <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      found_r <= 1'b0;
      right_r <= '0;
      left_r  <= '0;
    end else begin
      case (state)
        // DONE behaves like IDLE for acceptance so back-to-back searches
        // start without an idle gap; abort is not looked at here.
        S_IDLE, S_DONE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            rot_r   <= bus.src;
            tgt_r   <= bus.target;
            cnt     <= '0;
            found_r <= 1'b0;
            right_r <= '0;
            left_r  <= '0;
            busy_r  <= 1'b1;
            state   <= S_SEARCH;
          end else begin
            busy_r <= 1'b0;
            state  <= S_IDLE;
          end
        end

        // Abort outranks the compare; the compare is checked before the
        // last-candidate test so a match at k=WIDTH-1 is still reported.
        S_SEARCH: begin
          if (bus.abort) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            found_r <= 1'b0;
            right_r <= '0;
            left_r  <= '0;
            state   <= S_IDLE;
          end else if (rot_r == tgt_r) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            found_r <= 1'b1;
            right_r <= cnt;
            left_r  <= cnt_neg;
            state   <= S_DONE;
          end else if (cnt == CNT_LAST) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            found_r <= 1'b0;
            right_r <= '0;
            left_r  <= '0;
            state   <= S_DONE;
          end else begin
            rot_r <= {rot_r[0], rot_r[WIDTH-1:1]};
            cnt   <= cnt + 1'b1;
          end
        end

        default: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
  assign bus.found        = found_r;
  assign bus.amount_right = right_r;
  assign bus.amount_left  = left_r;

endmodule
`default_nettype wire

// File: tb/tb_rot_amount_finder.sv
`default_nettype none
// ============================================================================
// Module   : tb_rot_amount_finder
// Purpose  : Directed, table-driven bench for rot_amount_finder plus
//            hand-written sequences for start/abort/reset corner cases.
// Revision : 1.0  initial release
// ============================================================================
module tb_rot_amount_finder;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  logic clk;
  logic rst_n;
  int   cyc;
  int   e0;
  int   lat;
  int   busy_cnt;
  int   checks;
  int   failures;
  bit   got;

  rot_amount_finder_if #(.WIDTH(WIDTH), .SHW(SHW)) bus ();

  rot_amount_finder #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [31:0] src;
    logic [31:0] tgt;
    logic        found;
    logic [4:0]  right;
    logic [4:0]  left;
    int          lat;
  } vec_t;

  vec_t vecs [8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used to measure latency from the accepting edge
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present a request at a negedge; returns #1 after the accepting edge E0
  task automatic launch(input logic [31:0] s, input logic [31:0] t);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.src    = s;
    bus.target = t;
    @(posedge clk);
    #1;
    e0 = cyc;
    bus.start = 1'b0;
    busy_cnt = bus.busy ? 1 : 0;
  endtask

  // Waits (bounded) for the done pulse; lat = edges after E0
  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      #1;
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        ok  = 1'b1;
        lat = cyc - e0;
        return;
      end
    end
    lat = -1;
  endtask

  // Watches n cycles and reports whether done ever rose
  task automatic watch_done(input int n, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) seen = 1'b1;
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, " busy"},  32'(bus.busy),         32'd0);
    check({tag, " done"},  32'(bus.done),         32'd0);
    check({tag, " found"}, 32'(bus.found),        32'd0);
    check({tag, " right"}, 32'(bus.amount_right), 32'd0);
    check({tag, " left"},  32'(bus.amount_left),  32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    e0       = 0;
    bus.start  = 1'b0;
    bus.abort  = 1'b0;
    bus.src    = '0;
    bus.target = '0;

    vecs[0] = '{32'h12345678, 32'h78123456, 1'b1, 5'd8,  5'd24, 9};
    vecs[1] = '{32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 5'd0,  5'd0,  1};
    vecs[2] = '{32'h00000001, 32'h00000003, 1'b0, 5'd0,  5'd0,  32};
    vecs[3] = '{32'h80000000, 32'h00000001, 1'b1, 5'd31, 5'd1,  32};
    vecs[4] = '{32'hAAAAAAAA, 32'h55555555, 1'b1, 5'd1,  5'd31, 2};
    vecs[5] = '{32'h00000000, 32'h00000000, 1'b1, 5'd0,  5'd0,  1};
    vecs[6] = '{32'h0000FFFF, 32'hFFFF0000, 1'b1, 5'd16, 5'd16, 17};
    vecs[7] = '{32'h00000001, 32'h80000000, 1'b1, 5'd1,  5'd31, 2};

    // Reset state
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle busy", 32'(bus.busy), 32'd0);

    // Table-driven searches
    for (int i = 0; i < 8; i++) begin
      launch(vecs[i].src, vecs[i].tgt);
      check($sformatf("v%0d busy_after_accept", i), 32'(bus.busy), 32'd1);
      check($sformatf("v%0d found_cleared", i), 32'(bus.found), 32'd0);
      wait_done(got);
      check($sformatf("v%0d done_seen", i), 32'(got), 32'd1);
      check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d busy_cycles", i), 32'(busy_cnt), 32'(vecs[i].lat));
      check($sformatf("v%0d found", i), 32'(bus.found), 32'(vecs[i].found));
      check($sformatf("v%0d right", i), 32'(bus.amount_right), 32'(vecs[i].right));
      check($sformatf("v%0d left", i), 32'(bus.amount_left), 32'(vecs[i].left));
      @(posedge clk);
      #1;
      check($sformatf("v%0d done_one_cycle", i), 32'(bus.done), 32'd0);
      check($sformatf("v%0d found_held", i), 32'(bus.found), 32'(vecs[i].found));
      check($sformatf("v%0d right_held", i), 32'(bus.amount_right), 32'(vecs[i].right));
    end

    // start during SEARCH is ignored
    launch(32'h12345678, 32'h78123456);
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.src    = 32'hFFFFFFFF;
    bus.target = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(got);
    check("ign_start done_seen", 32'(got), 32'd1);
    check("ign_start latency", 32'(lat), 32'd9);
    check("ign_start found", 32'(bus.found), 32'd1);
    check("ign_start right", 32'(bus.amount_right), 32'd8);

    // abort mid-search: back to IDLE, no done pulse
    launch(32'h12345678, 32'h78123456);
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    check_zero_outputs("abort");
    watch_done(40, got);
    check("abort no_done", 32'(got), 32'd0);

    // start asserted in the DONE cycle is accepted with no idle gap
    launch(32'h12345678, 32'h78123456);
    wait_done(got);
    check("chain first_done", 32'(got), 32'd1);
    bus.start  = 1'b1;
    bus.src    = 32'h00000001;
    bus.target = 32'h00000003;
    @(posedge clk);
    #1;
    e0 = cyc;
    bus.start = 1'b0;
    check("chain busy_no_gap", 32'(bus.busy), 32'd1);
    check("chain done_low", 32'(bus.done), 32'd0);
    check("chain found_cleared", 32'(bus.found), 32'd0);
    check("chain right_cleared", 32'(bus.amount_right), 32'd0);
    wait_done(got);
    check("chain latency", 32'(lat), 32'd32);
    check("chain found", 32'(bus.found), 32'd0);

    // Asynchronous reset between edges mid-search
    launch(32'h12345678, 32'h78123456);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midreset");
    watch_done(12, got);
    check("midreset no_done", 32'(got), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    watch_done(12, got);
    check("after_reset no_done", 32'(got), 32'd0);
    launch(32'h0000FFFF, 32'hFFFF0000);
    wait_done(got);
    check("post_reset latency", 32'(lat), 32'd17);
    check("post_reset found", 32'(bus.found), 32'd1);
    check("post_reset right", 32'(bus.amount_right), 32'd16);
    check("post_reset left", 32'(bus.amount_left), 32'd16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
